sdp_sync_ram_be: RTL and testbench

- Simple dual-port synchronous RAM: one write port, one read port, both on `clk`.
- Per-byte write enables, configurable read latency (1 or 2) and selectable read-during-write semantics.
- After reset, an internal state machine zeroes every word before either port is accepted.
- Used as a generic buffer/scratchpad wherever single-port storage cannot sustain concurrent read and write traffic.

---
 rtl/sdp_sync_ram_be.sv | 189 ++++++++++++++++++
 tb/tb_sdp_sync_ram_be.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sdp_sync_ram_be.sv
// Simple dual-port RAM with byte enables, 1/2-cycle read latency, selectable read-during-write and a post-reset clear sweep.
// Optional per-byte even parity with error injection is enabled by defining SDP_RAM_PARITY_EN.
module sdp_sync_ram_be #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int OUT_REG    = 0,
    parameter int RDW_MODE   = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    output logic                    busy,
    input  logic                    wr_en,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    input  logic                    rd_en,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_valid
`ifdef SDP_RAM_PARITY_EN
    ,
    input  logic                    wr_perr_inj,
    output logic                    rd_perr
`endif
);

    localparam int NB = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_ptr;
    logic                    clear_we;
    logic                    ready;
    logic                    wr_in_range;
    logic                    rd_in_range;
    logic                    wr_fire;
    logic                    rd_fire;
    logic [DATA_WIDTH-1:0]   rd_word;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= CLEAR;
            clr_ptr <= '0;
        end else if (state == CLEAR) begin
            clr_ptr <= clr_ptr + 1'b1;
            if (clr_ptr == LAST_ADDR) begin
                state <= READY;
            end
        end
    end

    assign busy        = !rst_n || (state == CLEAR);
    assign clear_we    = rst_n && (state == CLEAR);
    assign ready       = rst_n && (state == READY);
    assign wr_in_range = {1'b0, wr_addr} < DEPTH_W;
    assign rd_in_range = {1'b0, rd_addr} < DEPTH_W;
    assign wr_fire     = ready && wr_en && wr_in_range;
    assign rd_fire     = ready && rd_en;

    // The clear sweep and user writes never overlap since they belong to different states.
    always_ff @(posedge clk) begin
        if (clear_we) begin
            mem[clr_ptr] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_word = '0;
        if (rd_in_range) begin
            rd_word = mem[rd_addr];
        end
        if (RDW_MODE == 1 && wr_fire && wr_addr == rd_addr) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    rd_word[8*i +: 8] = wr_data[8*i +: 8];
                end
            end
        end
    end

`ifdef SDP_RAM_PARITY_EN
    logic [NB-1:0] par [DEPTH];
    logic [NB-1:0] rd_par;
    logic          rd_bad;

    // Stored bit is the even-parity bit of the byte, optionally inverted to inject an error.
    always_ff @(posedge clk) begin
        if (clear_we) begin
            par[clr_ptr] <= '0;
        end else if (wr_fire) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    par[wr_addr][i] <= (^wr_data[8*i +: 8]) ^ wr_perr_inj;
                end
            end
        end
    end

    always_comb begin
        rd_par = '0;
        rd_bad = 1'b0;
        if (rd_in_range) begin
            rd_par = par[rd_addr];
        end
        if (RDW_MODE == 1 && wr_fire && wr_addr == rd_addr) begin
            for (int i = 0; i < NB; i++) begin
                if (wr_be[i]) begin
                    rd_par[i] = (^wr_data[8*i +: 8]) ^ wr_perr_inj;
                end
            end
        end
        for (int i = 0; i < NB; i++) begin
            if ((^rd_word[8*i +: 8]) != rd_par[i]) begin
                rd_bad = 1'b1;
            end
        end
    end
`endif

    generate
        if (OUT_REG == 0) begin : g_direct
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rd_data  <= '0;
                    rd_valid <= 1'b0;
`ifdef SDP_RAM_PARITY_EN
                    rd_perr  <= 1'b0;
`endif
                end else begin
                    rd_valid <= rd_fire;
                    if (rd_fire) begin
                        rd_data <= rd_word;
                    end
`ifdef SDP_RAM_PARITY_EN
                    rd_perr  <= rd_fire && rd_bad;
`endif
                end
            end
        end else begin : g_piped
            logic [DATA_WIDTH-1:0] stage_data;
            logic                  stage_valid;
`ifdef SDP_RAM_PARITY_EN
            logic                  stage_perr;
`endif

            // Reset flushes the middle stage so an in-flight read never surfaces.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    stage_data  <= '0;
                    stage_valid <= 1'b0;
                    rd_data     <= '0;
                    rd_valid    <= 1'b0;
`ifdef SDP_RAM_PARITY_EN
                    stage_perr  <= 1'b0;
                    rd_perr     <= 1'b0;
`endif
                end else begin
                    stage_valid <= rd_fire;
                    if (rd_fire) begin
                        stage_data <= rd_word;
                    end
                    rd_valid <= stage_valid;
                    if (stage_valid) begin
                        rd_data <= stage_data;
                    end
`ifdef SDP_RAM_PARITY_EN
                    stage_perr <= rd_fire && rd_bad;
                    rd_perr    <= stage_valid && stage_perr;
`endif
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sdp_sync_ram_be.sv
// Self-checking bench for sdp_sync_ram_be: two instances (1-cycle/old-data and 2-cycle/write-through)
// share stimulus and are compared against an array-based reference model.
module tb_sdp_sync_ram_be;

    localparam int AW    = 4;
    localparam int DW    = 32;
    localparam int NB    = DW / 8;
    localparam int DEPTH = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [NB-1:0] wr_be;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          busy0, busy1;
    logic [DW-1:0] rd_data0, rd_data1;
    logic          rd_valid0, rd_valid1;
`ifdef SDP_RAM_PARITY_EN
    logic          wr_perr_inj;
    logic          rd_perr0, rd_perr1;
`endif

    always #5 clk = ~clk;

    sdp_sync_ram_be #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .OUT_REG(0), .RDW_MODE(0)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .busy(busy0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data0), .rd_valid(rd_valid0)
`ifdef SDP_RAM_PARITY_EN
        , .wr_perr_inj(wr_perr_inj), .rd_perr(rd_perr0)
`endif
    );

    sdp_sync_ram_be #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .OUT_REG(1), .RDW_MODE(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .busy(busy1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1)
`ifdef SDP_RAM_PARITY_EN
        , .wr_perr_inj(wr_perr_inj), .rd_perr(rd_perr1)
`endif
    );

    // Reference model: word contents plus a mask of bytes whose parity was deliberately corrupted.
    logic [DW-1:0] model_mem [DEPTH];
    logic [NB-1:0] model_bad [DEPTH];
    logic [DW-1:0] exp_data0, exp_data1, pend_data;
    logic          exp_valid0, exp_valid1, pend_valid;
    logic          exp_perr0, exp_perr1, pend_perr;
    int            n_checks = 0;
    int            n_pass = 0;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic checkAll(input logic exp_busy);
        checkOutput("busy0", busy0, exp_busy);
        checkOutput("busy1", busy1, exp_busy);
        checkOutput("rd_valid0", rd_valid0, exp_valid0);
        checkOutput("rd_data0", rd_data0, exp_data0);
        checkOutput("rd_valid1", rd_valid1, exp_valid1);
        checkOutput("rd_data1", rd_data1, exp_data1);
`ifdef SDP_RAM_PARITY_EN
        checkOutput("rd_perr0", rd_perr0, exp_perr0);
        checkOutput("rd_perr1", rd_perr1, exp_perr1);
`endif
    endtask

    // One clock of normal traffic, followed by the model update and a full output check.
    task automatic applyStimulus(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                                 input logic [NB-1:0] wbe, input logic re, input logic [AW-1:0] ra,
                                 input logic inj);
        logic [DW-1:0] old_w, new_w;
        logic [NB-1:0] old_b, new_b;
        wr_en = we; wr_addr = wa; wr_data = wd; wr_be = wbe;
        rd_en = re; rd_addr = ra;
`ifdef SDP_RAM_PARITY_EN
        wr_perr_inj = inj;
`endif
        @(posedge clk);
        old_w = (int'(ra) < DEPTH) ? model_mem[ra] : '0;
        old_b = (int'(ra) < DEPTH) ? model_bad[ra] : '0;
        new_w = old_w;
        new_b = old_b;
        if (we && int'(wa) < DEPTH) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    model_mem[wa][8*i +: 8] = wd[8*i +: 8];
                    model_bad[wa][i] = inj;
                    if (wa == ra) begin
                        new_w[8*i +: 8] = wd[8*i +: 8];
                        new_b[i] = inj;
                    end
                end
            end
        end
        exp_valid0 = re;
        if (re) exp_data0 = old_w;
        exp_perr0 = re && (old_b != '0);
        exp_valid1 = pend_valid;
        if (pend_valid) exp_data1 = pend_data;
        exp_perr1 = pend_valid && pend_perr;
        pend_valid = re;
        pend_data = new_w;
        pend_perr = (new_b != '0);
        #1;
        checkAll(1'b0);
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic resetDut(input int edges);
        rst_n = 1'b0;
        wr_en = 1'b1; rd_en = 1'b1; wr_be = '1;
        wr_addr = AW'($urandom_range(0, 15)); rd_addr = AW'($urandom_range(0, 15));
        wr_data = $urandom;
        repeat (edges) @(posedge clk);
        #1;
        pend_valid = 1'b0; pend_perr = 1'b0; pend_data = '0;
        exp_valid0 = 1'b0; exp_valid1 = 1'b0;
        exp_data0 = '0; exp_data1 = '0;
        exp_perr0 = 1'b0; exp_perr1 = 1'b0;
        checkAll(1'b1);
        rst_n = 1'b1;
    endtask

    // Clear sweep with requests hammering both ports; busy must fall exactly after the DEPTH-th edge.
    task automatic sweepClear(input int abort_after);
        for (int k = 1; k <= DEPTH; k++) begin
            wr_en = 1'b1; rd_en = 1'b1; wr_be = '1;
            wr_addr = AW'($urandom_range(0, 15)); rd_addr = AW'($urandom_range(0, 15));
            wr_data = $urandom;
            @(posedge clk);
            #1;
            checkAll(k < DEPTH);
            if (k == abort_after) return;
        end
        for (int a = 0; a < DEPTH; a++) begin
            model_mem[a] = '0;
            model_bad[a] = '0;
        end
    endtask

    initial begin
        logic          we, re, inj;
        logic [AW-1:0] wa, ra;
        rst_n = 1'b0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0;
        rd_en = 1'b0; rd_addr = '0;
`ifdef SDP_RAM_PARITY_EN
        wr_perr_inj = 1'b0;
`endif
        $display("[TB] start");
        resetDut(2);
        sweepClear(0);

        for (int a = 0; a < 16; a++) applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0);
        idle();

        applyStimulus(1'b1, 4'd3, 32'hAABBCCDD, 4'b1111, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 4'd3, 32'h11223344, 4'b0101, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0);
        checkOutput("be_merge0", rd_data0, 32'hAA22CC44);
        idle();
        checkOutput("be_merge1", rd_data1, 32'hAA22CC44);
        applyStimulus(1'b1, 4'd3, 32'h55555555, 4'b0000, 1'b1, 4'd3, 1'b0);
        idle();

        for (int a = 0; a < 4; a++) applyStimulus(1'b1, AW'(a), DW'(a), 4'b1111, 1'b0, '0, 1'b0);
        for (int a = 0; a < 4; a++) applyStimulus(1'b0, '0, '0, '0, 1'b1, AW'(a), 1'b0);
        checkOutput("lat_v1", rd_valid1, 1'b1);
        checkOutput("lat_d1", rd_data1, 32'd2);
        idle();
        checkOutput("lat_last", rd_data1, 32'd3);
        idle();
        checkOutput("lat_end", rd_valid1, 1'b0);

        applyStimulus(1'b1, 4'd5, 32'h1, 4'b1111, 1'b0, '0, 1'b0);
        applyStimulus(1'b1, 4'd5, 32'h2, 4'b1111, 1'b1, 4'd5, 1'b0);
        checkOutput("rdw_old", rd_data0, 32'h1);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd5, 1'b0);
        checkOutput("rdw_new", rd_data1, 32'h2);
        checkOutput("rdw_after0", rd_data0, 32'h2);
        idle();

        applyStimulus(1'b1, 4'd13, 32'hFFFFFFFF, 4'b1111, 1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd13, 1'b0);
        checkOutput("oor_valid", rd_valid0, 1'b1);
        checkOutput("oor_data", rd_data0, 32'h0);
        idle();

        applyStimulus(1'b1, 4'd2, 32'h000000A5, 4'b0001, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd2, 1'b0);
        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd1, 1'b0);
`ifdef SDP_RAM_PARITY_EN
        checkOutput("perr_inj", rd_perr1, 1'b1);
        checkOutput("perr_clean", rd_perr0, 1'b0);
`endif
        idle();

        for (int n = 0; n < 400; n++) begin
            we = 1'($urandom); re = 1'($urandom);
            wa = AW'($urandom_range(0, 15));
            ra = ($urandom_range(0, 1) == 0) ? wa : AW'($urandom_range(0, 15));
            inj = ($urandom_range(0, 7) == 0);
            applyStimulus(we, wa, $urandom, NB'($urandom), re, ra, inj);
        end

        applyStimulus(1'b0, '0, '0, '0, 1'b1, 4'd3, 1'b0);
        resetDut(1);
        sweepClear(7);
        resetDut(1);
        sweepClear(0);

        for (int n = 0; n < 200; n++) begin
            we = 1'($urandom); re = 1'($urandom);
            wa = AW'($urandom_range(0, 15));
            ra = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 15));
            applyStimulus(we, wa, $urandom, NB'($urandom), re, ra, ($urandom_range(0, 7) == 0));
        end
        idle();
        idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
